// File: rtl/bcd_timekeeper_scan.sv
// bcd_timekeeper_scan: BCD time counter with load validation, alarm compare and multiplexed 7-segment scan with digit blink
module bcd_timekeeper_scan #(
  parameter int NUM_DIGITS = 4,
  parameter int TOP_MAX    = 59,
  parameter int SCAN_DIV   = 50000,
  parameter int BLINK_DIV  = 25000000
) (
  input  logic                    clk,
  input  logic                    resetn,
  input  logic                    tick,
  input  logic                    run,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] load_val,
  input  logic [4*NUM_DIGITS-1:0] alarm_val,
  input  logic                    alarm_en,
  input  logic [NUM_DIGITS-1:0]   edit_sel,
  output logic [4*NUM_DIGITS-1:0] time_bcd,
  output logic                    wrap,
  output logic                    load_err,
  output logic                    alarm_hit,
  output logic [NUM_DIGITS-1:0]   anode,
  output logic [6:0]              seg
);
  localparam int NF = NUM_DIGITS / 2;
  localparam int SW = $clog2(SCAN_DIV + 1);
  localparam int BW = $clog2(BLINK_DIV + 1);
  localparam int IW = NUM_DIGITS > 1 ? $clog2(NUM_DIGITS) : 1;
  localparam logic [3:0] TOP_T = 4'(TOP_MAX / 10);
  localparam logic [3:0] TOP_U = 4'(TOP_MAX % 10);
  logic [4*NUM_DIGITS-1:0] inc_val;
  logic                    carry;
  logic                    load_ok;
  logic                    match;
  logic                    match_q;
  logic [SW-1:0]           scan_cnt;
  logic [BW-1:0]           blink_cnt;
  logic [IW-1:0]           idx;
  logic                    phase;
  logic [3:0]              digit;
  logic [6:0]              seg_d;
  // ripple increment across fields; carry out of the top field means full rollover
  always_comb begin
    inc_val = time_bcd;
    carry = 1'b1;
    for (int f = 0; f < NF; f++) begin
      if (carry) begin
        if (f == NF - 1 && time_bcd[8*f+4 +: 4] == TOP_T && time_bcd[8*f +: 4] == TOP_U)
          inc_val[8*f +: 8] = 8'h00;
        else if (time_bcd[8*f +: 4] == 4'd9) begin
          inc_val[8*f +: 4] = 4'd0;
          if (f != NF - 1 && time_bcd[8*f+4 +: 4] == 4'd5)
            inc_val[8*f+4 +: 4] = 4'd0;
          else begin
            inc_val[8*f+4 +: 4] = time_bcd[8*f+4 +: 4] + 4'd1;
            carry = 1'b0;
          end
        end else begin
          inc_val[8*f +: 4] = time_bcd[8*f +: 4] + 4'd1;
          carry = 1'b0;
        end
      end
    end
  end
  // a load is legal only if every digit is decimal and every field is within its range
  always_comb begin
    load_ok = 1'b1;
    for (int f = 0; f < NF; f++) begin
      if (load_val[8*f +: 4] > 4'd9 || load_val[8*f+4 +: 4] > 4'd9)
        load_ok = 1'b0;
      if (f == NF - 1)
        load_ok = load_ok && (int'(load_val[8*f+4 +: 4]) * 10 + int'(load_val[8*f +: 4]) <= TOP_MAX);
      else if (load_val[8*f+4 +: 4] > 4'd5)
        load_ok = 1'b0;
    end
  end
  // time register: load wins over tick, a rejected load leaves the time untouched
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      time_bcd <= '0;
      wrap     <= 1'b0;
      load_err <= 1'b0;
    end else begin
      time_bcd <= load ? (load_ok ? load_val : time_bcd) : (tick && run ? inc_val : time_bcd);
      wrap     <= !load && tick && run && carry;
      load_err <= load && !load_ok;
    end
  end
  assign match = alarm_en && time_bcd == alarm_val;
  // alarm pulses on the rising edge of the enabled match
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      match_q   <= 1'b0;
      alarm_hit <= 1'b0;
    end else begin
      match_q   <= match;
      alarm_hit <= match && !match_q;
    end
  end
  // scan slot counter: advance the active digit every SCAN_DIV cycles
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      scan_cnt <= '0;
      idx      <= '0;
    end else if (scan_cnt == SW'(SCAN_DIV - 1)) begin
      scan_cnt <= '0;
      idx      <= idx == IW'(NUM_DIGITS - 1) ? '0 : idx + 1'b1;
    end else
      scan_cnt <= scan_cnt + 1'b1;
  end
  // blink phase toggles every BLINK_DIV cycles, starting visible
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      blink_cnt <= '0;
      phase     <= 1'b1;
    end else if (blink_cnt == BW'(BLINK_DIV - 1)) begin
      blink_cnt <= '0;
      phase     <= ~phase;
    end else
      blink_cnt <= blink_cnt + 1'b1;
  end
  assign digit = time_bcd[{idx, 2'b00} +: 4];
  // seven-segment decode of the active digit, non-decimal codes blank
  always_comb begin
    case (digit)
      4'd0:    seg_d = 7'b0111111;
      4'd1:    seg_d = 7'b0000110;
      4'd2:    seg_d = 7'b1011011;
      4'd3:    seg_d = 7'b1001111;
      4'd4:    seg_d = 7'b1100110;
      4'd5:    seg_d = 7'b1101101;
      4'd6:    seg_d = 7'b1111101;
      4'd7:    seg_d = 7'b0000111;
      4'd8:    seg_d = 7'b1111111;
      4'd9:    seg_d = 7'b1101111;
      default: seg_d = 7'b0000000;
    endcase
  end
  // registered display drive; a selected digit goes dark during blink phase 0
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      anode <= '1;
      seg   <= '0;
    end else begin
      anode <= edit_sel[idx] && !phase ? '1 : ~(NUM_DIGITS'(1) << idx);
      seg   <= seg_d;
    end
  end
endmodule
